tv_capture: RTL

- Synthesizable capture unit: the writer side of the bench test-vector flow.
- Samples each applied DUT stimulus and the DUT response after a fixed settle delay, then stores the packed word {stim, resp} in an internal buffer.
- Buffer is streamed out in order over a valid/ready port, so a host or bench can dump it in the same {input, expected_output} layout used by the vector files.
- Sits beside a DUT in hardware test harnesses.

---
 rtl/tv_capture_pkg.sv | 24 ++
 rtl/tv_capture_mem.sv | 28 ++
 rtl/tv_capture.sv | 131 +++++++++++++
 3 files changed

// File: rtl/tv_capture_pkg.sv
// Shared types and helpers for the test-vector capture unit.
package tv_capture_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_SETTLE,
    S_WRITE,
    S_DUMP,
    S_DONE
  } tv_state_e;

  localparam int DEPTH_DEF = 64;
  localparam int PTR_W     = $clog2(DEPTH_DEF);
  localparam int CNT_W     = PTR_W + 1;

  // Packs {stim, resp} with stim in the MSBs; callers truncate to IN_W+OUT_W.
  function automatic logic [63:0] pack_entry(input logic [31:0] stim,
                                             input logic [31:0] resp,
                                             input int          out_w);
    return (64'(stim) << out_w) | 64'(resp);
  endfunction

endpackage

// File: rtl/tv_capture_mem.sv
// DEPTH x W capture buffer: one write port, one registered read port.
module tv_capture_mem #(
  parameter int DEPTH = 64,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [W-1:0]             wr_data,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [W-1:0]             rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Output register keeps a sync reset so rd_data reads 0 after reset.
  always_ff @(posedge clk) begin
    if (reset)   rd_data <= '0;
    else if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/tv_capture.sv
// Captures {stimulus, settled response} pairs and streams them back in order.
module tv_capture
  import tv_capture_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int OUT_W  = 8,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int SETTLE = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    vec_valid,
  input  logic [IN_W-1:0]         vec_in,
  input  logic [OUT_W-1:0]        dut_out,
  output logic                    busy,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count,
  output logic [15:0]             dropped,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [IN_W+OUT_W-1:0]   rd_data,
  output logic                    done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int W     = IN_W + OUT_W;
  localparam int SC_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  tv_state_e         state, nxt;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_addr;
  logic [IN_W-1:0]   stim_q;
  logic [OUT_W-1:0]  resp_q;
  logic [SC_W-1:0]   settle_cnt;
  logic              stop_pend;
  logic              accept, wr_en, rd_en, xfer, last;
  logic [W-1:0]      wr_data;

  assign busy    = (state == S_SETTLE) || (state == S_WRITE);
  assign full    = (count == CNT_W'(DEPTH));
  assign done    = (state == S_DONE);
  assign wr_data = W'(pack_entry(32'(stim_q), 32'(resp_q), OUT_W));
  assign rd_addr = rd_ptr + PTR_W'(xfer);

  always_comb begin
    nxt    = state;
    accept = 1'b0;
    wr_en  = 1'b0;
    xfer   = rd_valid && rd_ready;
    last   = xfer && (CNT_W'(rd_ptr) == count - CNT_W'(1));
    case (state)
      S_IDLE:   if (start) nxt = S_ARMED;
      S_ARMED: begin
        if (stop || full) nxt = S_DUMP;
        else if (vec_valid) begin
          nxt    = S_SETTLE;
          accept = 1'b1;
        end
      end
      S_SETTLE: if (settle_cnt == '0) nxt = S_WRITE;
      S_WRITE: begin
        wr_en = 1'b1;
        // This write fills the buffer, or a stop arrived while busy.
        if (stop_pend || stop || count == CNT_W'(DEPTH - 1)) nxt = S_DUMP;
        else nxt = S_ARMED;
      end
      S_DUMP:   if (count == '0 || last) nxt = S_DONE;
      S_DONE:   if (start) nxt = S_ARMED;
      default:  nxt = S_IDLE;
    endcase
    // Prefetch the next entry on a transfer so rd_valid has no bubbles.
    rd_en = (state == S_DUMP) && (count != '0) && (!rd_valid || xfer) && !last;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      dropped    <= '0;
      rd_valid   <= 1'b0;
      stop_pend  <= 1'b0;
      stim_q     <= '0;
      resp_q     <= '0;
      settle_cnt <= '0;
    end else begin
      state <= nxt;
      if ((state == S_IDLE || state == S_DONE) && start) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        dropped   <= '0;
        stop_pend <= 1'b0;
      end
      if (accept) begin
        stim_q     <= vec_in;
        settle_cnt <= SC_W'(SETTLE - 1);
      end
      if (state == S_SETTLE) begin
        if (settle_cnt == '0) resp_q <= dut_out;
        else                  settle_cnt <= settle_cnt - SC_W'(1);
      end
      if (busy && vec_valid && dropped != 16'hFFFF) dropped <= dropped + 16'd1;
      if (busy && stop) stop_pend <= 1'b1;
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        count  <= count + CNT_W'(1);
      end
      if (state == S_DUMP) begin
        stop_pend <= 1'b0;
        rd_valid  <= (count != '0) && !last;
        if (xfer) rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  tv_capture_mem #(.DEPTH(DEPTH), .W(W)) u_mem (
    .clk     (clk),
    .reset   (reset),
    .we      (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .re      (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule
